// File: rtl/mantle_cmp_stream_if.sv
// mantle_cmp_stream_if: operand/result stream for mantle_cmp_stream.
// The master drives operands and consumes the result; the slave is the comparator.
interface mantle_cmp_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [2:0]       MODE;
    logic             I_valid;
    logic             I_ready;
    logic             O;
    logic             O_valid;
    logic             O_ready;
    modport slave (input I0, I1, MODE, I_valid, O_ready, output I_ready, O, O_valid);
    modport master (output I0, I1, MODE, I_valid, O_ready, input I_ready, O, O_valid);
endinterface

// File: rtl/mantle_cmp_stream.sv
// mantle_cmp_stream: registered streaming comparator (EQ/NE/LT/LE/GT/GE) with running max of I0.
// Define MANTLE_CMP_STATS_EN to add the saturating HITS counter of true accepted results.
module mantle_cmp_stream #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    mantle_cmp_stream_if.slave s,
    input  logic               CLR,
    output logic [WIDTH-1:0]   MAX,
    output logic               MAX_valid
`ifdef MANTLE_CMP_STATS_EN
    ,
    output logic [CNT_W-1:0]   HITS
`endif
);
    logic accept, eq, lt, gt_max, res;
    assign s.I_ready = !s.O_valid || s.O_ready;
    assign accept    = s.I_valid && s.I_ready;
    assign eq        = s.I0 == s.I1;
    assign lt        = SIGNED ? ($signed(s.I0) < $signed(s.I1)) : (s.I0 < s.I1);
    assign gt_max    = SIGNED ? ($signed(s.I0) > $signed(MAX)) : (s.I0 > MAX);
    always_comb begin
        case (s.MODE)
            3'd0:    res = eq;
            3'd1:    res = !eq;
            3'd2:    res = lt;
            3'd3:    res = lt || eq;
            3'd4:    res = !(lt || eq);
            3'd5:    res = !lt;
            default: res = 1'b0;
        endcase
    end
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            s.O       <= 1'b0;
            s.O_valid <= 1'b0;
        end else if (accept) begin
            s.O       <= res;
            s.O_valid <= 1'b1;
        end else if (s.O_ready) begin
            s.O_valid <= 1'b0;
        end
    end
    // CLR together with an accept restarts the sequence at this sample
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            MAX       <= '0;
            MAX_valid <= 1'b0;
        end else if (accept) begin
            if (!MAX_valid || CLR || gt_max) MAX <= s.I0;
            MAX_valid <= 1'b1;
        end else if (CLR) begin
            MAX_valid <= 1'b0;
        end
    end
`ifdef MANTLE_CMP_STATS_EN
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) HITS <= '0;
        else if (accept && res) HITS <= CLR ? CNT_W'(1) : (&HITS ? HITS : HITS + CNT_W'(1));
        else if (CLR) HITS <= '0;
    end
`else
    localparam int cnt_w_unused = CNT_W;
`endif
endmodule

// File: tb/tb_mantle_cmp_stream.sv
// tb_mantle_cmp_stream: scoreboard bench driving a signed and an unsigned comparator in lockstep.
module tb_mantle_cmp_stream;
    localparam int W     = 8;
    localparam int CW    = 2;
    localparam int H_SAT = 3;
    typedef struct {
        logic s;
        logic u;
    } exp_t;
    logic CLK, ASYNCRESETN, CLR;
    logic [W-1:0] max_s, max_u;
    logic mv_s, mv_u;
    logic [CW-1:0] hits_s, hits_u;
    int checks = 0, failures = 0;
    exp_t sb[$];
    logic ov, mv;
    logic [W-1:0] ms, mu;
    int hs, hu;
    mantle_cmp_stream_if #(.WIDTH(W)) b ();
    mantle_cmp_stream_if #(.WIDTH(W)) bu ();
    assign bu.I0      = b.I0;
    assign bu.I1      = b.I1;
    assign bu.MODE    = b.MODE;
    assign bu.I_valid = b.I_valid;
    assign bu.O_ready = b.O_ready;
    mantle_cmp_stream #(.WIDTH(W), .SIGNED(1'b1), .CNT_W(CW)) u_s (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .s(b), .CLR(CLR), .MAX(max_s), .MAX_valid(mv_s)
`ifdef MANTLE_CMP_STATS_EN
        , .HITS(hits_s)
`endif
    );
    mantle_cmp_stream #(.WIDTH(W), .SIGNED(1'b0), .CNT_W(CW)) u_u (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .s(bu), .CLR(CLR), .MAX(max_u), .MAX_valid(mv_u)
`ifdef MANTLE_CMP_STATS_EN
        , .HITS(hits_u)
`endif
    );
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int sval(input logic [W-1:0] x, input bit sgn);
        return (sgn && x[W-1]) ? int'(x) - (1 << W) : int'(x);
    endfunction
    function automatic logic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] c, input logic [2:0] md, input bit sgn);
        int x = sval(a, sgn);
        int y = sval(c, sgn);
        case (md)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd2:    return x < y;
            3'd3:    return x <= y;
            3'd4:    return x > y;
            3'd5:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction
    function automatic int next_hits(input int h, input logic acc, input logic r, input logic clr);
        if (acc && r) return clr ? 1 : (h == H_SAT ? H_SAT : h + 1);
        return clr ? 0 : h;
    endfunction
    task automatic model_reset();
        sb.delete();
        ov = 0; mv = 0; ms = '0; mu = '0; hs = 0; hu = 0;
    endtask
    // one clock: check state left by the last edge, drive the next inputs, predict the next edge
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] c, input logic [2:0] md,
                         input logic clr, input logic ordy);
        logic acc;
        exp_t e;
        @(posedge CLK);
        #2;
        chk("o_valid", b.O_valid, ov);
        chk("o_valid_u", bu.O_valid, ov);
        chk("max_valid", mv_s, mv);
        chk("max_valid_u", mv_u, mv);
        if (mv) begin
            chk("max_s", max_s, ms);
            chk("max_u", max_u, mu);
        end
`ifdef MANTLE_CMP_STATS_EN
        chk("hits_s", hits_s, hs);
        chk("hits_u", hits_u, hu);
`endif
        b.I_valid = v; b.I0 = a; b.I1 = c; b.MODE = md; CLR = clr; b.O_ready = ordy;
        #1;
        chk("i_ready", b.I_ready, !ov || ordy);
        acc = v && (!ov || ordy);
        e.s = ref_cmp(a, c, md, 1'b1);
        e.u = ref_cmp(a, c, md, 1'b0);
        if (acc) sb.push_back(e);
        hs = next_hits(hs, acc, e.s, clr);
        hu = next_hits(hu, acc, e.u, clr);
        ov = acc ? 1'b1 : (ordy ? 1'b0 : ov);
        if (acc) begin
            if (!mv || clr || sval(a, 1'b1) > sval(ms, 1'b1)) ms = a;
            if (!mv || clr || a > mu) mu = a;
            mv = 1'b1;
        end else if (clr) begin
            mv = 1'b0;
        end
    endtask
    task automatic idle();
        cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
    endtask
    task automatic reset_checks(input string tag);
        chk({tag, "_o"}, b.O, 0);
        chk({tag, "_o_valid"}, b.O_valid, 0);
        chk({tag, "_o_valid_u"}, bu.O_valid, 0);
        chk({tag, "_max_valid"}, mv_s, 0);
        chk({tag, "_max"}, max_s, 0);
        chk({tag, "_i_ready"}, b.I_ready, 1);
`ifdef MANTLE_CMP_STATS_EN
        chk({tag, "_hits"}, hits_s, 0);
`endif
    endtask
    task automatic async_reset();
        @(posedge CLK);
        #2;
        ASYNCRESETN = 1'b0;
        b.I_valid = 1'b0;
        CLR = 1'b0;
        #1;
        reset_checks("arst");
        model_reset();
        @(posedge CLK);
        #2;
        ASYNCRESETN = 1'b1;
    endtask
    // monitor: every presented result must match the oldest outstanding prediction
    initial begin
        forever begin
            @(negedge CLK);
            if (ASYNCRESETN && b.O_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty actual=O_valid required=no_result at %0t", $time);
                end else begin
                    chk("o_s", b.O, sb[0].s);
                    chk("o_u", bu.O, sb[0].u);
                    if (b.O_ready) void'(sb.pop_front());
                end
            end
        end
    end
    initial begin
        logic [7:0] sweep;
        logic [W-1:0] a, c;
        sweep = 8'b0010_1001;
        ASYNCRESETN = 1'b0;
        CLR = 1'b0;
        b.I_valid = 1'b0; b.I0 = '0; b.I1 = '0; b.MODE = '0; b.O_ready = 1'b1;
        model_reset();
        #1;
        reset_checks("por");
        repeat (2) @(posedge CLK);
        #2;
        ASYNCRESETN = 1'b1;
        cycle(1'b1, 8'h80, 8'h7F, 3'd2, 1'b0, 1'b1);
        idle();
        chk("lt_signed", b.O, 1);
        chk("lt_unsigned", bu.O, 0);
        for (int m = 0; m < 8; m++) begin
            cycle(1'b1, 8'h05, 8'h05, 3'(m), 1'b0, 1'b1);
            idle();
            chk("mode_sweep", b.O, sweep[m]);
        end
        cycle(1'b1, 8'h10, 8'h20, 3'd2, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, W'($urandom), W'($urandom), 3'd4, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 5)), 1'b0, 1'b1);
        idle();
        cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1);
        cycle(1'b1, 8'hF0, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1);
        idle();
        chk("max_seq", max_s, 8'h03);
        chk("max_seq_u", max_u, 8'hFF);
        cycle(1'b1, 8'h81, 8'h00, 3'd0, 1'b1, 1'b1);
        idle();
        chk("max_clr", max_s, 8'h81);
        chk("max_clr_valid", mv_s, 1);
`ifdef MANTLE_CMP_STATS_EN
        cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1);
        repeat (5) cycle(1'b1, 8'h22, 8'h22, 3'd0, 1'b0, 1'b1);
        idle();
        chk("hits_sat", hits_s, 3);
        cycle(1'b1, 8'h22, 8'h22, 3'd0, 1'b1, 1'b1);
        idle();
        chk("hits_clr", hits_s, 1);
`endif
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            c = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            cycle($urandom_range(0, 3) != 0, a, c, 3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0);
            if (i == 1000) async_reset();
        end
        cycle(1'b1, 8'h40, 8'h41, 3'd1, 1'b0, 1'b0);
        async_reset();
        repeat (3) idle();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
